// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding HI/LO for MFHI/MFLO.
// One shift-add or restoring-divide step per cycle on magnitudes; signs fixed up at the end.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWre,
    input  logic             LoWre,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} stateT;

    stateT              state, nextState;
    logic [CW-1:0]      count;
    logic [1:0]         opReg;
    logic [WIDTH-1:0]   bMag;
    logic [2*WIDTH-1:0] work, workNext, prodFix;
    logic               negLo, negHi, divZero;
    logic               aNeg, bNeg;
    logic [WIDTH-1:0]   aMagIn, bMagIn, hiFix, loFix;
    logic [WIDTH:0]     addSum, shifted, diff;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which fits unsigned.
    always_comb begin
        aNeg   = ~Op[0] & A[WIDTH-1];
        bNeg   = ~Op[0] & B[WIDTH-1];
        aMagIn = aNeg ? -A : A;
        bMagIn = bNeg ? -B : B;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (Start) nextState = RUN;
            RUN:     if (count == CW'(WIDTH - 1)) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
        Busy = (state != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!Reset) state <= IDLE;
        else        state <= nextState;
    end

    // work holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        addSum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, bMag} : '0);
        shifted = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
        diff    = shifted - {1'b0, bMag};
        if (opReg[1]) begin
            if (shifted >= {1'b0, bMag})
                workNext = {diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
            else
                workNext = {shifted[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
        end else begin
            workNext = {addSum, work[WIDTH-1:1]};
        end

        prodFix = negLo ? -work : work;
        if (opReg[1]) begin
            // With a zero divisor every step subtracts nothing, leaving |A| in the
            // remainder half; re-applying the dividend sign restores raw A.
            hiFix = negHi ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];
            loFix = divZero ? '1 : (negLo ? -work[WIDTH-1:0] : work[WIDTH-1:0]);
        end else begin
            hiFix = prodFix[2*WIDTH-1:WIDTH];
            loFix = prodFix[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            count   <= '0;
            opReg   <= '0;
            bMag    <= '0;
            work    <= '0;
            negLo   <= 1'b0;
            negHi   <= 1'b0;
            divZero <= 1'b0;
            Done    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (HiWre) HI <= WriteData;
                    if (LoWre) LO <= WriteData;
                    if (Start) begin
                        opReg   <= Op;
                        work    <= {{WIDTH{1'b0}}, aMagIn};
                        bMag    <= bMagIn;
                        negLo   <= aNeg ^ bNeg;
                        negHi   <= aNeg;
                        divZero <= (B == '0);
                        count   <= '0;
                    end
                end
                RUN: begin
                    work  <= workNext;
                    count <= count + CW'(1);
                end
                FIX: begin
                    HI   <= hiFix;
                    LO   <= loFix;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes reference results, a Done-driven
// monitor pops and compares HI/LO.
module tb_muldiv_unit;
    localparam int unsigned WIDTH = 32;

    logic        CLK = 1'b0;
    logic        Reset, Start, HiWre, LoWre;
    logic [1:0]  Op;
    logic [31:0] A, B, WriteData;
    logic        Busy, Done;
    logic [31:0] HI, LO;

    int unsigned checks = 0;
    int unsigned passes = 0;
    logic [63:0] expQ[$];
    logic        prevDone = 1'b0;

    always #5 CLK = ~CLK;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
        .HiWre(HiWre), .LoWre(LoWre), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: plain 64-bit arithmetic; SV signed / and % truncate toward zero.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q, r;
        logic [63:0] res;
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = {32'h0, a} * {32'h0, b};
            2'b10: begin
                if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: res = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
        endcase
        return res;
    endfunction

    always @(negedge CLK) begin
        if (Reset && Done) begin
            check("donePulseWidth", {63'h0, prevDone}, 64'h0);
            if (expQ.size() == 0) begin
                check("unexpectedDone", 64'h1, 64'h0);
            end else begin
                logic [63:0] e;
                e = expQ.pop_front();
                check("resultHI", {32'h0, HI}, {32'h0, e[63:32]});
                check("resultLO", {32'h0, LO}, {32'h0, e[31:0]});
            end
        end
        prevDone <= Done;
    end

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Start = 1'b1; Op = op; A = a; B = b;
        // MT write on the launch edge is legal and must be overwritten by the result
        LoWre = 1'($urandom_range(1, 0)); WriteData = $urandom;
        expQ.push_back(model(op, a, b));
        @(negedge CLK);
        Start = 1'b0; LoWre = 1'b0; A = $urandom; B = $urandom;
    endtask

    task automatic waitBusy(input int injectAt);
        int n = 0;
        while (Busy && n < 200) begin
            if (n == injectAt) begin
                Start = 1'b1; Op = 2'b11; A = 32'd9; B = 32'd0;
                HiWre = 1'b1; WriteData = 32'hDEAD_BEEF;
            end else begin
                Start = 1'b0;
                HiWre = 1'($urandom_range(1, 0));
                LoWre = 1'($urandom_range(1, 0));
                WriteData = $urandom;
            end
            n++;
            @(negedge CLK);
        end
        Start = 1'b0; HiWre = 1'b0; LoWre = 1'b0;
        check("busyCycles", 64'(n), 64'(WIDTH + 1));
    endtask

    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        launch(op, a, b);
        waitBusy(-1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Start = 1'b0; HiWre = 1'b0; LoWre = 1'b0;
        Op = 2'b00; A = '0; B = '0; WriteData = '0;
        repeat (3) @(negedge CLK);
        check("resetBusy", {63'h0, Busy}, 64'h0);
        check("resetDone", {63'h0, Done}, 64'h0);
        check("resetHILO", {HI, LO}, 64'h0);
        Reset = 1'b1;

        runOp(2'b00, 32'hFFFF_FFFD, 32'd7);
        runOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2);
        runOp(2'b11, 32'd100, 32'd7);
        runOp(2'b11, 32'h1234, 32'd0);
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(2'b10, 32'hFFFF_FFF9, 32'd0);
        runOp(2'b00, 32'h8000_0000, 32'h8000_0000);
        runOp(2'b00, 32'h8000_0000, 32'd1);

        // Start and MTHI while busy must be ignored
        launch(2'b01, 32'd3, 32'd5);
        waitBusy(9);
        @(negedge CLK);
        check("noRestart", {63'h0, Busy}, 64'h0);
        check("ignoredMthi", {HI, LO}, 64'h0000_0000_0000_000F);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(3, 0));
            a  = ($urandom_range(7, 0) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(7, 0))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(15, 1);
                default: b = $urandom;
            endcase
            runOp(op, a, b);
        end

        // Abort a DIV mid-run: no Done, HI/LO cleared
        @(negedge CLK);
        Start = 1'b1; Op = 2'b10; A = 32'hFFFF_0000; B = 32'd3;
        @(negedge CLK);
        Start = 1'b0;
        repeat (11) @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        check("abortBusy", {63'h0, Busy}, 64'h0);
        check("abortHILO", {HI, LO}, 64'h0);
        repeat (40) @(negedge CLK);
        check("abortStaysIdle", {63'h0, Busy}, 64'h0);

        LoWre = 1'b1; WriteData = 32'h0000_ABCD;
        @(negedge CLK);
        LoWre = 1'b0;
        check("mtlo", {HI, LO}, 64'h0000_0000_0000_ABCD);
        HiWre = 1'b1; LoWre = 1'b1; WriteData = 32'h1357_9BDF;
        @(negedge CLK);
        HiWre = 1'b0; LoWre = 1'b0;
        check("mthiMtlo", {HI, LO}, 64'h1357_9BDF_1357_9BDF);

        runOp(2'b00, 32'd6, 32'hFFFF_FFF9);
        repeat (5) @(negedge CLK);
        check("scoreboardEmpty", 64'(expQ.size()), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
